buf_scanout_reader: RTL and testbench

//  Read-side master for the 24-bit RGB frame buffer. Generates raster timing
//  (h/v counters, sync, data-enable) and issues read strobes and addresses.

---
 rtl/buf_scanout_reader.sv | 217 +++++++++++++++++++++
 tb/tb_buf_scanout_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_scanout_reader.sv
// Read-side scan-out master for the 24-bit RGB frame buffer.
// Generates raster timing, issues read strobes with row-major addresses,
// and registers the returned bytes into a pixel stream whose sync, enable
// and frame-start flags are delayed to line up exactly with the data.
//
// Read strobe protocol: buf_re is a fixed-latency request with no
// back-pressure. When buf_re=1 in cycle t, buf_addr is valid in cycle t and
// the buffer presents buf_r/g/b in cycle t+1. The block captures that data
// at the end of t+1, so it appears on pix_* during t+2. There is no ready
// signal; the buffer must always answer with one-cycle latency.
module buf_scanout_reader #(
  parameter int H_ACTIVE = 100,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 100,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              buf_re,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_r,
  input  logic [7:0]        buf_g,
  input  logic [7:0]        buf_b,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              wr_window,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Raster geometry derived from the porch/sync parameters.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // IDLE: parked, counters at origin. RUN: scanning with enable high.
  // DRAIN: enable dropped, finishing the current frame before parking.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] addr;

  // Issue-stage (cycle t) decode.
  logic          scanning;
  logic          h_last;
  logic          v_last;
  logic          frame_last;
  logic          stop;
  logic          active_now;
  logic          next_re;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          hs_now;
  logic          vs_now;
  logic          fs_now;

  // First pipeline stage: flags travelling alongside the buffer read.
  logic de_d1;
  logic hs_d1;
  logic vs_d1;
  logic fs_d1;

  function automatic logic is_active(input logic [HW-1:0] h, input logic [VW-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  // Raster position decode, next-position lookahead and write-window logic.
  always_comb begin
    scanning   = (state != S_IDLE);
    h_last     = (h_cnt == H_LAST);
    v_last     = (v_cnt == V_LAST);
    frame_last = h_last && v_last;
    // Scanning stops only at the last clock of a frame with enable low.
    stop       = scanning && frame_last && !enable;
    active_now = is_active(h_cnt, v_cnt);

    h_nxt = h_last ? '0 : h_cnt + HW'(1);
    v_nxt = v_cnt;
    if (h_last) begin
      v_nxt = v_last ? '0 : v_cnt + VW'(1);
    end

    // Will a read be issued next cycle? Leaving IDLE always lands on the
    // first active pixel, so the lookahead there is simply enable.
    next_re = 1'b0;
    if (state == S_IDLE) begin
      next_re = enable;
    end else if (!stop) begin
      next_re = is_active(h_nxt, v_nxt);
    end

    hs_now = scanning && (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    vs_now = scanning && (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    fs_now = scanning && (h_cnt == '0) && (v_cnt == '0);
  end

  // Issue-stage outputs come straight from registered state/counters.
  assign buf_re    = scanning && active_now;
  assign buf_we    = 1'b0;
  assign buf_addr  = addr;
  assign busy      = scanning;
  assign dbg_state = state;
  // The writer may use the port only when no read happens now or next
  // cycle; held low while reset is asserted so every output reads 0.
  assign wr_window = reset && !buf_re && !next_re;

  // Scan FSM with h/v counters and running read address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          addr  <= '0;
          if (enable) begin
            state <= S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          h_cnt <= h_nxt;
          v_cnt <= v_nxt;
          // Address restarts at the frame wrap; otherwise it steps once per
          // active read, so no multiply is needed to form v*H_ACTIVE+h.
          if (frame_last) begin
            addr <= '0;
          end else if (buf_re) begin
            addr <= addr + ADDR_W'(1);
          end
          if (stop) begin
            state <= S_IDLE;
          end else if (enable) begin
            state <= S_RUN;
          end else begin
            state <= S_DRAIN;
          end
        end
        default: begin
          state <= S_IDLE;
          h_cnt <= '0;
          v_cnt <= '0;
          addr  <= '0;
        end
      endcase
    end
  end

  // Stage 1: delay timing flags by one clock while the buffer returns data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_d1 <= 1'b0;
      hs_d1 <= 1'b0;
      vs_d1 <= 1'b0;
      fs_d1 <= 1'b0;
    end else begin
      de_d1 <= buf_re;
      hs_d1 <= hs_now;
      vs_d1 <= vs_now;
      fs_d1 <= fs_now;
    end
  end

  // Stage 2: register returned bytes with flags; blank data outside de.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
      pix_de      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_r       <= de_d1 ? buf_r : 8'd0;
      pix_g       <= de_d1 ? buf_g : 8'd0;
      pix_b       <= de_d1 ? buf_b : 8'd0;
      pix_de      <= de_d1;
      hsync       <= hs_d1;
      vsync       <= vs_d1;
      frame_start <= fs_d1;
    end
  end

endmodule

// File: tb/tb_buf_scanout_reader.sv
// Testbench for buf_scanout_reader: table of raster points for the first
// frame plus hand-written sequences for drain, re-enable and mid-frame reset.
module tb_buf_scanout_reader;

  localparam int FRAME = 12960;

  // Clock and reset block.
  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #5 clk = ~clk;

  logic        buf_re, buf_we;
  logic [19:0] buf_addr;
  logic [7:0]  buf_r, buf_g, buf_b;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_de, hsync, vsync, frame_start, wr_window, busy;
  logic [1:0]  dbg_state;

  buf_scanout_reader dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .buf_re     (buf_re),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_r      (buf_r),
    .buf_g      (buf_g),
    .buf_b      (buf_b),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .pix_de     (pix_de),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .wr_window  (wr_window),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: one-cycle read latency, {G,B,R} = address; garbage otherwise.
  always @(posedge clk) begin
    if (buf_re) {buf_g, buf_b, buf_r} <= 24'(buf_addr);
    else        {buf_g, buf_b, buf_r} <= 24'hA5C35A;
  end

  // Scoreboard: expected pixel queue filled by reads, drained by pix_de.
  logic [23:0] exp_q[$];
  logic [23:0] exp_pix;
  int stream_err = 0;
  int rd_cnt     = 0;
  int ww_viol    = 0;
  int max_addr   = 0;
  int last_fs    = -1;
  int fs_period  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (pix_de) begin
        if (exp_q.size() == 0) stream_err++;
        else begin
          exp_pix = exp_q.pop_front();
          if ({pix_g, pix_b, pix_r} !== exp_pix) stream_err++;
        end
      end else if ({pix_r, pix_g, pix_b} !== 24'd0) begin
        stream_err++;
      end
      if (buf_re) begin
        exp_q.push_back(24'(buf_addr));
        rd_cnt++;
        if (int'(buf_addr) > max_addr) max_addr = int'(buf_addr);
      end
      if (buf_re && wr_window) ww_viol++;
      if (frame_start) begin
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Driver: advance to issue-cycle index target of the current scan, then
  // settle 1 time unit past the falling edge before sampling or driving.
  int pos;
  task automatic goto(input int target);
    if (pos < target) begin
      while (pos < target) begin
        @(negedge clk);
        pos++;
      end
      #1;
    end
  endtask

  typedef struct packed {
    int          k;
    logic        re;
    logic [19:0] addr;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] pix;
    logic        ww;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int k, input logic re, input int addr,
                              input logic de, input logic hs, input logic vs,
                              input logic fs, input int pix, input logic ww);
    vec_t v;
    v.k = k; v.re = re; v.addr = 20'(addr); v.de = de; v.hs = hs;
    v.vs = vs; v.fs = fs; v.pix = 24'(pix); v.ww = ww;
    return v;
  endfunction

  int rd0;

  initial begin
    // k = issue cycle since frame start; pix fields describe position k-2.
    //                 k     re addr  de hs vs fs pix   ww
    vecs.push_back(mk(0,     1, 0,    0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(1,     1, 1,    0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(2,     1, 2,    1, 0, 0, 1, 0,    0));
    vecs.push_back(mk(3,     1, 3,    1, 0, 0, 0, 1,    0));
    vecs.push_back(mk(99,    1, 99,   1, 0, 0, 0, 97,   0));
    vecs.push_back(mk(100,   0, 0,    1, 0, 0, 0, 98,   1));
    vecs.push_back(mk(101,   0, 0,    1, 0, 0, 0, 99,   1));
    vecs.push_back(mk(102,   0, 0,    0, 0, 0, 0, 0,    1));
    vecs.push_back(mk(106,   0, 0,    0, 1, 0, 0, 0,    1));
    vecs.push_back(mk(113,   0, 0,    0, 1, 0, 0, 0,    1));
    vecs.push_back(mk(114,   0, 0,    0, 0, 0, 0, 0,    1));
    vecs.push_back(mk(119,   0, 0,    0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(120,   1, 100,  0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(122,   1, 102,  1, 0, 0, 0, 100,  0));
    vecs.push_back(mk(11979, 1, 9999, 1, 0, 0, 0, 9997, 0));
    vecs.push_back(mk(11981, 0, 0,    1, 0, 0, 0, 9999, 1));
    vecs.push_back(mk(12005, 0, 0,    0, 0, 0, 0, 0,    1));
    vecs.push_back(mk(12252, 0, 0,    0, 0, 1, 0, 0,    1));
    vecs.push_back(mk(12468, 0, 0,    0, 1, 1, 0, 0,    1));
    vecs.push_back(mk(12484, 0, 0,    0, 0, 0, 0, 0,    1));
    vecs.push_back(mk(12959, 0, 0,    0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(12960, 1, 0,    0, 0, 0, 0, 0,    0));
    vecs.push_back(mk(12962, 1, 2,    1, 0, 0, 1, 0,    0));
    vecs.push_back(mk(12963, 1, 3,    1, 0, 0, 0, 1,    0));

    // Reset state.
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", 32'({buf_re, buf_we, pix_de, hsync, vsync, frame_start, wr_window, busy, dbg_state}), 0);
    check("rst_addr", 32'(buf_addr), 0);
    check("rst_pix", 32'({pix_r, pix_g, pix_b}), 0);

    reset = 1'b1;
    #1;
    check("idle_ww", 32'(wr_window), 1);
    check("idle_busy", 32'(busy), 0);
    enable = 1'b1;
    #1;
    check("idle_exit_ww", 32'(wr_window), 0);

    // First frame and start of the second, table driven.
    rd0 = rd_cnt;
    pos = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      goto(vecs[i].k);
      check($sformatf("v%0d_re", i), 32'(buf_re), 32'(vecs[i].re));
      if (vecs[i].re) check($sformatf("v%0d_addr", i), 32'(buf_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_de", i), 32'(pix_de), 32'(vecs[i].de));
      check($sformatf("v%0d_hs", i), 32'(hsync), 32'(vecs[i].hs));
      check($sformatf("v%0d_vs", i), 32'(vsync), 32'(vecs[i].vs));
      check($sformatf("v%0d_fs", i), 32'(frame_start), 32'(vecs[i].fs));
      check($sformatf("v%0d_pix", i), 32'({pix_g, pix_b, pix_r}), 32'(vecs[i].pix));
      check($sformatf("v%0d_ww", i), 32'(wr_window), 32'(vecs[i].ww));
    end
    check("frame_reads", rd_cnt - rd0, 10004);
    check("max_addr", max_addr, 9999);
    check("frame_period", fs_period, FRAME);

    // Drop enable at v=50 of the second frame: frame completes, then IDLE.
    goto(FRAME + 6000);
    check("pre_drop_state", 32'(dbg_state), 1);
    enable = 1'b0;
    goto(FRAME + 6001);
    check("drain_state", 32'(dbg_state), 2);
    check("drain_re", 32'(buf_re), 1);
    check("drain_addr", 32'(buf_addr), 5001);
    goto(FRAME + 7210);
    check("drain_v60_addr", 32'(buf_addr), 6010);
    check("drain_v60_busy", 32'(busy), 1);
    goto(FRAME + 12959);
    check("drain_last_busy", 32'(busy), 1);
    check("drain_last_ww", 32'(wr_window), 1);
    goto(FRAME + 12960);
    check("parked_busy", 32'(busy), 0);
    check("parked_state", 32'(dbg_state), 0);
    check("parked_ww", 32'(wr_window), 1);
    check("parked_re", 32'(buf_re), 0);
    goto(FRAME + 12965);
    check("parked_de", 32'(pix_de), 0);

    // Restart, then drop and re-raise enable inside DRAIN: no frame restart.
    enable = 1'b1;
    pos = -1;
    goto(0);
    check("restart_addr", 32'(buf_addr), 0);
    check("restart_re", 32'(buf_re), 1);
    goto(2400);
    enable = 1'b0;
    goto(2401);
    check("redrain_state", 32'(dbg_state), 2);
    goto(2520);
    enable = 1'b1;
    goto(2521);
    check("rerun_state", 32'(dbg_state), 1);
    goto(3605);
    check("rerun_re", 32'(buf_re), 1);
    check("rerun_addr", 32'(buf_addr), 3005);

    // Asynchronous reset at v=30, h=40.
    goto(3640);
    check("pre_rst_addr", 32'(buf_addr), 3040);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ctl", 32'({buf_re, buf_we, pix_de, hsync, vsync, frame_start, wr_window, busy, dbg_state}), 0);
    check("async_rst_addr", 32'(buf_addr), 0);
    check("async_rst_pix", 32'({pix_r, pix_g, pix_b}), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("post_rst_de", 32'(pix_de), 0);
    check("post_rst_busy", 32'(busy), 0);
    enable = 1'b1;
    pos = -1;
    goto(0);
    check("post_rst_addr", 32'(buf_addr), 0);
    check("post_rst_re", 32'(buf_re), 1);
    goto(2);
    check("post_rst_fs", 32'(frame_start), 1);
    check("post_rst_de1", 32'(pix_de), 1);
    enable = 1'b0;
    goto(10);

    check("stream", stream_err, 0);
    check("ww_overlap", ww_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
